// File: rtl/atm_pin_timer_if.sv
// ----------------------------------------------------------------------------
// atm_pin_timer_if
// Bundles the session control, keypad and result signals between the ATM
// control side and atm_pin_timer.
//   master : drives start_timer, restart_timer, card_pin, digit_valid, digit,
//            digit_clear; observes timeout, wrong_psw, psw_ok, digit_count
//   slave  : the mirror image, used by atm_pin_timer
// ----------------------------------------------------------------------------
interface atm_pin_timer_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned CountW = $clog2(DIGITS + 1);

    logic                  start_timer;
    logic                  restart_timer;
    logic [4*DIGITS-1:0]   card_pin;
    logic                  digit_valid;
    logic [3:0]            digit;
    logic                  digit_clear;
    logic                  timeout;
    logic                  wrong_psw;
    logic                  psw_ok;
    logic [CountW-1:0]     digit_count;

    modport master (
        output start_timer, restart_timer, card_pin, digit_valid, digit, digit_clear,
        input  timeout, wrong_psw, psw_ok, digit_count
    );

    modport slave (
        input  start_timer, restart_timer, card_pin, digit_valid, digit, digit_clear,
        output timeout, wrong_psw, psw_ok, digit_count
    );
endinterface

// File: rtl/atm_pin_timer.sv
// ----------------------------------------------------------------------------
// atm_pin_timer
// Collects BCD PIN digits from the keypad, compares them against the card PIN
// and pulses psw_ok / wrong_psw for one cycle. Also runs the session
// inactivity timer that pulses timeout.
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : atm_pin_timer_if.slave (session control, keypad, results)
// All outputs are registered.
// ----------------------------------------------------------------------------
module atm_pin_timer #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 10
) (
    input logic             clk,
    input logic             rst,
    atm_pin_timer_if.slave  bus
);
    localparam int unsigned          CountW = $clog2(DIGITS + 1);
    localparam int unsigned          BufW   = 4 * DIGITS;
    localparam logic [CNT_W-1:0]     TmrMax = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CountW-1:0]    LastCnt = CountW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StCheck} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  tmr_q, tmr_d;
    logic              tmo_q, tmo_d;
    logic [BufW-1:0]   buf_q;
    logic [CountW-1:0] count_q;
    logic              ok_q, wrong_q;
    logic              digit_ok;

    assign digit_ok = bus.digit_valid && (bus.digit <= 4'd9);

    // Inactivity timer; any keypad strobe counts as activity, even a non-BCD key.
    always_comb begin
        tmr_d = tmr_q + 1'b1;
        tmo_d = 1'b0;
        if (!bus.start_timer) begin
            tmr_d = '0;
        end else if (bus.restart_timer || bus.digit_valid) begin
            tmr_d = '0;
        end else if (tmr_q == TmrMax) begin
            tmr_d = '0;
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmr_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            tmo_q <= tmo_d;
        end
    end

    // Entry FSM with registered result pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            buf_q   <= '0;
            count_q <= '0;
            ok_q    <= 1'b0;
            wrong_q <= 1'b0;
        end else begin
            ok_q    <= 1'b0;
            wrong_q <= 1'b0;
            if (!bus.start_timer) begin
                // Session dropped: abandon entry, including a pending compare.
                state_q <= StIdle;
                buf_q   <= '0;
                count_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        buf_q   <= '0;
                        count_q <= '0;
                        state_q <= StCollect;
                    end
                    StCollect: begin
                        // tmo_d and digit_valid are exclusive: a strobe reloads the timer.
                        if (bus.digit_clear || tmo_d) begin
                            buf_q   <= '0;
                            count_q <= '0;
                        end else if (digit_ok) begin
                            buf_q   <= {buf_q[BufW-5:0], bus.digit};
                            count_q <= count_q + 1'b1;
                            if (count_q == LastCnt) begin
                                state_q <= StCheck;
                            end
                        end
                    end
                    StCheck: begin
                        ok_q    <= (buf_q == bus.card_pin);
                        wrong_q <= (buf_q != bus.card_pin);
                        buf_q   <= '0;
                        count_q <= '0;
                        state_q <= StCollect;
                    end
                    default: begin
                        state_q <= StIdle;
                        buf_q   <= '0;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.timeout     = tmo_q;
    assign bus.psw_ok      = ok_q;
    assign bus.wrong_psw   = wrong_q;
    assign bus.digit_count = count_q;

endmodule
